// File: rtl/mem_line_bank_pkg.sv
// Shared types and constants for the drum line bank: sequencer states and
// the two standard drum line lengths.
package g15_mem_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam int DRUM_LEN_LONG  = 116;
  localparam int DRUM_LEN_SHORT = 4;

endpackage

// File: rtl/mem_line_bank_drum_track.sv
// One recirculating drum track: an N-bit delay line with no reset, so a bit
// presented on din reappears on dout exactly N clocks later.
module drum_track #(
  parameter int N = 116
) (
  input  logic clk,
  input  logic din,
  output logic dout
);

  logic [N-1:0] sr;

  always_ff @(posedge clk) begin
    sr <= {sr[N-2:0], din};
  end

  assign dout = sr[N-1];

endmodule

// File: rtl/mem_line_bank.sv
// Bank of NLINES recirculating drum lines with a shared bit-position counter,
// a reset/clear/run sequencer, write-protect mask and per-line write logic.
module mem_line_bank
  import g15_mem_pkg::*;
#(
  parameter int                NLINES = 3,
  parameter int                LEN    = DRUM_LEN_LONG,
  parameter logic [NLINES-1:0] GO_CLR = NLINES'(3'b110)
) (
  input  logic              CLOCK,
  input  logic              rst,
  input  logic              LB,
  input  logic              D5,
  input  logic [NLINES-1:0] dsel,
  input  logic              TR,
  input  logic              GO,
  input  logic [NLINES-1:0] ext_set,
  input  logic              wp_load,
  input  logic [NLINES-1:0] wp_data,
  output logic [NLINES-1:0] line_out,
  output logic [$clog2(LEN)-1:0] pos,
  output logic              word_mark,
  output logic              ready
);

  localparam int PW = $clog2(LEN);

  state_t            state;
  state_t            state_nxt;
  logic              pos_last;
  logic [NLINES-1:0] wp;
  logic [NLINES-1:0] sel;
  logic [NLINES-1:0] run_bit;
  logic [NLINES-1:0] track_in;
  logic [NLINES-1:0] track_out;

  assign pos_last = (pos == PW'(LEN - 1));

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      state <= RST;
    end else begin
      state <= state_nxt;
    end
  end

  // CLEAR reuses pos as its sweep counter: one full revolution, then RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      RST:     state_nxt = CLEAR;
      CLEAR:   if (pos_last) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = RST;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (rst || state == RST) begin
      pos <= '0;
    end else if (pos_last) begin
      pos <= '0;
    end else begin
      pos <= pos + 1'b1;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      wp <= '0;
    end else if (wp_load && state != RST) begin
      wp <= wp_data;
    end
  end

  // In RST the tracks simply keep circulating; only CLEAR zeroes them.
  always_comb begin
    sel      = '0;
    run_bit  = '0;
    track_in = track_out;
    for (int n = 0; n < NLINES; n++) begin
      sel[n]     = D5 & dsel[n] & ~wp[n];
      run_bit[n] = (LB & sel[n]) | ext_set[n] |
                   (track_out[n] & ~(TR & sel[n]) & ~(GO & GO_CLR[n]));
    end
    case (state)
      RUN:     track_in = run_bit;
      CLEAR:   track_in = '0;
      default: track_in = track_out;
    endcase
  end

  for (genvar n = 0; n < NLINES; n++) begin : g_line
    drum_track #(.N(LEN)) u_track (
      .clk  (CLOCK),
      .din  (track_in[n]),
      .dout (track_out[n])
    );
  end

  assign ready     = (state == RUN);
  assign word_mark = ready && (pos == '0);
  assign line_out  = ready ? track_out : '0;

endmodule

// File: tb/tb_mem_line_bank.sv
// Directed bench for mem_line_bank: reset/clear sequencing, overwrite and
// merge writes, GO clear, write protect, word mark and mid-operation reset.
module tb_mem_line_bank;

  localparam int LEN = 116;
  localparam int NL  = 3;

  logic          CLOCK = 1'b0;
  logic          rst;
  logic          LB;
  logic          D5;
  logic [NL-1:0] dsel;
  logic          TR;
  logic          GO;
  logic [NL-1:0] ext_set;
  logic          wp_load;
  logic [NL-1:0] wp_data;
  logic [NL-1:0] line_out;
  logic [6:0]    pos;
  logic          word_mark;
  logic          ready;

  int total = 0;
  int bad   = 0;

  logic [LEN-1:0] cap [NL];
  logic [LEN-1:0] exp_q [$];

  mem_line_bank #(.NLINES(NL), .LEN(LEN)) dut (
    .CLOCK     (CLOCK),
    .rst       (rst),
    .LB        (LB),
    .D5        (D5),
    .dsel      (dsel),
    .TR        (TR),
    .GO        (GO),
    .ext_set   (ext_set),
    .wp_load   (wp_load),
    .wp_data   (wp_data),
    .line_out  (line_out),
    .pos       (pos),
    .word_mark (word_mark),
    .ready     (ready)
  );

  // clock / reset block
  always #5 CLOCK = ~CLOCK;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic idle();
    LB = 0; D5 = 0; dsel = '0; TR = 0; GO = 0;
    ext_set = '0; wp_load = 0; wp_data = '0;
  endtask

  task automatic wait_pos0();
    for (int i = 0; i < LEN + 2 && pos !== 7'd0; i++) step();
    total++;
    if (pos !== 7'd0) begin
      bad++;
      $display("FAIL wait_pos0 timeout pos=%0d exp=0", pos);
    end
  endtask

  // Records one revolution of every line, indexed by bit position.
  task automatic capture();
    for (int p = 0; p < LEN; p++) begin
      for (int n = 0; n < NL; n++) cap[n][pos] = line_out[n];
      step();
    end
  endtask

  task automatic count_to_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 300) begin
      step();
      n++;
    end
    total++;
    if (n !== LEN) begin
      bad++;
      $display("FAIL %s ready_latency got=%0d exp=%0d", name, n, LEN);
    end
  endtask

  task automatic check_lines(input string name);
    logic [LEN-1:0] e;
    for (int n = 0; n < NL; n++) begin
      e = exp_q.pop_front();
      total++;
      if (cap[n] !== e) begin
        bad++;
        $display("FAIL %s line%0d got=%h exp=%h", name, n, cap[n], e);
      end
    end
  endtask

  task automatic test_reset();
    int nz;
    idle();
    rst = 1;
    step(); step(); step();
    total++;
    if ({pos, ready, word_mark, line_out} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got pos=%0d rdy=%b wm=%b lo=%b exp all 0",
               pos, ready, word_mark, line_out);
    end
    rst = 0;
    step();
    total++;
    if (pos !== 7'd0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_first_cycle got pos=%0d rdy=%b exp pos=0 rdy=0", pos, ready);
    end
    nz = 0;
    for (int i = 0; i < LEN - 1; i++) begin
      step();
      if (line_out !== '0) nz++;
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL clear_line_out_forced got=%0d nonzero cycles exp=0", nz);
    end
    step();
    total++;
    if (ready !== 1'b1 || pos !== 7'd0 || word_mark !== 1'b1) begin
      bad++;
      $display("FAIL run_entry got rdy=%b pos=%0d wm=%b exp 1/0/1", ready, pos, word_mark);
    end
  endtask

  task automatic test_preload_clear();
    int nz;
    wait_pos0();
    for (int p = 0; p < LEN; p++) begin
      D5 = 1; dsel = 3'b111; TR = 1; LB = 1;
      step();
    end
    idle();
    capture();
    for (int n = 0; n < NL; n++) exp_q.push_back({LEN{1'b1}});
    check_lines("preload");
    rst = 1;
    step(); step(); step();
    rst = 0;
    step();
    count_to_ready("preload_clear");
    nz = 0;
    for (int i = 0; i < LEN; i++) begin
      if (line_out !== '0) nz++;
      step();
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL cleared_drum got=%0d nonzero cycles exp=0", nz);
    end
  endtask

  task automatic test_overwrite();
    logic [LEN-1:0] e0;
    wait_pos0();
    for (int p = 0; p < LEN; p++) begin
      idle();
      if (p == 5)  begin D5 = 1; dsel = 3'b001; TR = 1; LB = 1; end
      if (p == 20) begin D5 = 1; dsel = 3'b001; LB = 1; end
      step();
    end
    idle();
    capture();
    e0 = '0; e0[5] = 1'b1; e0[20] = 1'b1;
    exp_q.push_back(e0); exp_q.push_back('0); exp_q.push_back('0);
    check_lines("overwrite");
  endtask

  task automatic test_back_to_back();
    logic [LEN-1:0] e0, e2;
    wait_pos0();
    for (int p = 0; p < LEN; p++) begin
      idle();
      if (p == 20) begin D5 = 1; dsel = 3'b001; TR = 1; LB = 0; end
      if (p == 21 || p == 22) begin D5 = 1; dsel = 3'b100; LB = 1; end
      step();
    end
    idle();
    capture();
    e0 = '0; e0[5] = 1'b1;
    e2 = '0; e2[21] = 1'b1; e2[22] = 1'b1;
    exp_q.push_back(e0); exp_q.push_back('0); exp_q.push_back(e2);
    check_lines("back_to_back");
  endtask

  task automatic test_go_clear();
    logic [LEN-1:0] e0, e1, e2;
    wait_pos0();
    for (int p = 0; p < LEN; p++) begin
      idle();
      D5 = 1; dsel = 3'b110; TR = 1; LB = 1;
      step();
    end
    for (int p = 0; p < LEN; p++) begin
      idle();
      GO = 1;
      if (p == 7)  begin D5 = 1; dsel = 3'b010; TR = 1; LB = 1; end
      if (p == 9)  begin D5 = 1; dsel = 3'b001; TR = 1; LB = 0; ext_set = 3'b001; end
      if (p == 30) ext_set = 3'b100;
      step();
    end
    idle();
    capture();
    e0 = '0; e0[5] = 1'b1; e0[9] = 1'b1;
    e1 = '0; e1[7] = 1'b1;
    e2 = '0; e2[30] = 1'b1;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    check_lines("go_clear");
  endtask

  task automatic test_write_protect();
    logic [LEN-1:0] e0, e1, e2;
    e0 = '0; e0[5] = 1'b1; e0[9] = 1'b1;
    e2 = '0; e2[30] = 1'b1;
    wait_pos0();
    for (int p = 0; p < LEN; p++) begin
      idle();
      D5 = 1; dsel = 3'b010; TR = 1; LB = 1;
      if (p == LEN - 1) begin wp_load = 1; wp_data = 3'b010; end
      step();
    end
    for (int p = 0; p < LEN; p++) begin
      idle();
      D5 = 1; dsel = 3'b010; TR = 1; LB = 0;
      step();
    end
    idle();
    capture();
    exp_q.push_back(e0); exp_q.push_back({LEN{1'b1}}); exp_q.push_back(e2);
    check_lines("wp_protected");
    for (int p = 0; p < LEN; p++) begin
      idle();
      D5 = 1; dsel = 3'b010; TR = 1; LB = 0;
      if (p == 0) begin wp_load = 1; wp_data = 3'b000; end
      step();
    end
    idle();
    capture();
    e1 = '0; e1[0] = 1'b1;
    exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
    check_lines("wp_released");
  endtask

  task automatic test_wrap_mark();
    int marks, first_t, last_t, gap_bad, pos_bad;
    marks = 0; first_t = -1; last_t = -1; gap_bad = 0; pos_bad = 0;
    idle();
    step();
    for (int t = 0; t < 3 * LEN; t++) begin
      if (word_mark === 1'b1) begin
        marks++;
        if (pos !== 7'd0) pos_bad++;
        if (last_t >= 0 && (t - last_t) != LEN) gap_bad++;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
      step();
    end
    total++;
    if (marks !== 3) begin
      bad++;
      $display("FAIL word_mark_count got=%0d exp=3", marks);
    end
    total++;
    if (gap_bad !== 0 || pos_bad !== 0) begin
      bad++;
      $display("FAIL word_mark_spacing got gap_bad=%0d pos_bad=%0d exp 0/0", gap_bad, pos_bad);
    end
  endtask

  task automatic test_mid_reset();
    logic [LEN-1:0] e;
    idle();
    wp_load = 1; wp_data = 3'b111;
    step();
    idle();
    rst = 1;
    step();
    rst = 0;
    step();
    for (int i = 0; i < 50; i++) step();
    total++;
    if (pos !== 7'd50 || ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_cycle50 got pos=%0d rdy=%b exp pos=50 rdy=0", pos, ready);
    end
    rst = 1;
    step();
    total++;
    if ({pos, ready, word_mark, line_out} !== '0) begin
      bad++;
      $display("FAIL mid_reset got pos=%0d rdy=%b wm=%b lo=%b exp all 0",
               pos, ready, word_mark, line_out);
    end
    rst = 0;
    step();
    count_to_ready("mid_reset");
    wait_pos0();
    for (int p = 0; p < LEN; p++) begin
      idle();
      if (p == 3) begin D5 = 1; dsel = 3'b111; TR = 1; LB = 1; end
      step();
    end
    idle();
    capture();
    e = '0; e[3] = 1'b1;
    for (int n = 0; n < NL; n++) exp_q.push_back(e);
    check_lines("after_mid_reset");
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_preload_clear();
    test_overwrite();
    test_back_to_back();
    test_go_clear();
    test_write_protect();
    test_wrap_mark();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
